// File: rtl/pot_spi_ctrl_pkg.sv
// Shared definitions for the digital-pot SPI master: FSM encoding,
// default frame width and the pot command-word field layout.
package pot_spi_ctrl_pkg;

    localparam int DEFAULT_POT_W = 16;

    // Width of the small phase counters (CLK_DIV and CS_* are at most 255)
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Pot command word layout as seen by software: [addr|cmd|data]
    localparam int POT_ADDR_MSB = 15;
    localparam int POT_ADDR_LSB = 12;
    localparam int POT_CMD_MSB  = 11;
    localparam int POT_CMD_LSB  = 10;
    localparam int POT_DATA_MSB = 9;
    localparam int POT_DATA_LSB = 0;

    function automatic logic [DEFAULT_POT_W-1:0] pot_word(
        input logic [POT_ADDR_MSB-POT_ADDR_LSB:0] addr,
        input logic [POT_CMD_MSB-POT_CMD_LSB:0]   cmd,
        input logic [POT_DATA_MSB-POT_DATA_LSB:0] data
    );
        return {addr, cmd, data};
    endfunction

endpackage

// File: rtl/pot_spi_ctrl_if.sv
// Request/completion handshake between the selector-register stage
// (master) and the pot SPI controller (slave).
interface pot_spi_ctrl_if
    import pot_spi_ctrl_pkg::*;
#(
    parameter int DATA_W = DEFAULT_POT_W
);
    logic              send_data_spi;
    logic [DATA_W-1:0] dat_spi_out;
    logic              send_ok_strobe;
    logic              pot_busy;

    modport master (
        output send_data_spi, dat_spi_out,
        input  send_ok_strobe, pot_busy
    );

    modport slave (
        input  send_data_spi, dat_spi_out,
        output send_ok_strobe, pot_busy
    );
endinterface

// File: rtl/pot_spi_ctrl_spi_tick_gen.sv
// One-cycle tick every CLK_DIV enabled cycles; the counter restarts from
// zero whenever enable drops so the first tick after enable is CLK_DIV away.
module spi_tick_gen
    import pot_spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_,
    input  logic en,
    output logic tick
);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    assign tick = en && (div_cnt == DIV_LAST);

    // Divider counter: free-runs while enabled, wraps on each tick
    always_ff @(posedge clk) begin
        if (rst_ || !en || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end
endmodule

// File: rtl/pot_spi_ctrl.sv
// SPI mode-0 master for the selector-mux digital pot. Takes a level
// request plus word, shifts it out MSB first, captures MISO, and returns
// a one-cycle completion strobe and a busy flag. All outputs registered.
module pot_spi_ctrl
    import pot_spi_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_POT_W,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst_,
    pot_spi_ctrl_if.slave     up,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [DATA_W-1:0] rx_data
);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] SETUP_N   = CNT_W'(CS_SETUP);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [BIT_W-1:0]  bit_cnt, bit_d;
    logic [DATA_W-1:0] tx_sh, tx_d;
    logic [DATA_W-1:0] rx_sh, rx_d;
    logic [DATA_W-1:0] rx_data_d;
    logic              arm, arm_d;
    logic              cs_d, sclk_d, mosi_d;
    logic              busy_q, busy_d;
    logic              strobe_q, strobe_d;
    logic              tick_en, tick;

    assign up.pot_busy       = busy_q;
    assign up.send_ok_strobe = strobe_q;

    // SCLK divider runs once CS setup has elapsed and through the shift phase;
    // the last CLK_DIV cycles of SETUP lead into the first rising edge.
    assign tick_en = ((state == SETUP) && (cnt >= SETUP_N)) || (state == SHIFT);

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst_ (rst_),
        .en   (tick_en),
        .tick (tick)
    );

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_d     = bit_cnt;
        tx_d      = tx_sh;
        rx_d      = rx_sh;
        rx_data_d = rx_data;
        cs_d      = spi_cs_n;
        sclk_d    = spi_sclk;
        mosi_d    = spi_mosi;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        // Re-arm whenever the request is seen low, so a held request fires once
        arm_d     = arm | ~up.send_data_spi;

        case (state)
            IDLE: begin
                if (up.send_data_spi && arm) begin
                    tx_d    = up.dat_spi_out;
                    mosi_d  = up.dat_spi_out[DATA_W-1];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    arm_d   = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt < SETUP_N)
                    cnt_d = cnt + 1'b1;
                // The tick that ends SETUP is also the first rising edge
                if (tick) begin
                    sclk_d  = 1'b1;
                    rx_d    = {rx_sh[DATA_W-2:0], spi_miso};
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!spi_sclk) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_sh[DATA_W-2:0], spi_miso};
                    end else begin
                        sclk_d = 1'b0;
                        tx_d   = {tx_sh[DATA_W-2:0], 1'b0};
                        mosi_d = tx_sh[DATA_W-2];
                        if (bit_cnt == BIT_LAST) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            bit_d = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cs_d      = 1'b1;
                    rx_data_d = rx_sh;
                    strobe_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = GAP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset wins over any pending strobe
    always_ff @(posedge clk) begin
        if (rst_) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            arm      <= 1'b1;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_d;
            tx_sh    <= tx_d;
            rx_sh    <= rx_d;
            rx_data  <= rx_data_d;
            arm      <= arm_d;
            spi_cs_n <= cs_d;
            spi_sclk <= sclk_d;
            spi_mosi <= mosi_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
        end
    end
endmodule
